inv_transform_recon: RTL

INV_TRANSFORM_RECON -- requirements
Module: inv_transform_recon

---
 rtl/inv_transform_recon.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/inv_transform_recon.sv
// 4x4 inverse integer transform plus prediction add and clamp.
// One shared 1-D butterfly runs four column passes, then four row passes,
// writing one reconstructed row per row pass. A block takes 9 cycles.
// The prediction port is named ref_pix because ref is a reserved word.

// 1-D four-point inverse butterfly. It is shared by the column and row passes.
module inv_transform_recon_bfly #(
  parameter int W = 33
) (
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] x3,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3
);
  localparam logic signed [W-1:0] K1 = W'(20091);
  localparam logic signed [W-1:0] K2 = W'(35468);

  // The products are taken at full precision, then floor-shifted.
  function automatic logic signed [W-1:0] m1(input logic signed [W-1:0] x);
    logic signed [W-1:0] p;
    p = x * K1;
    return (p >>> 16) + x;
  endfunction

  function automatic logic signed [W-1:0] m2(input logic signed [W-1:0] x);
    logic signed [W-1:0] p;
    p = x * K2;
    return p >>> 16;
  endfunction

  logic signed [W-1:0] a, b, c, d;

  // Butterfly: even part (a, b) and rotated odd part (c, d)
  always_comb begin
    a  = x0 + x2;
    b  = x0 - x2;
    c  = m2(x1) - m1(x3);
    d  = m1(x1) + m2(x3);
    y0 = a + d;
    y1 = b + c;
    y2 = b - c;
    y3 = a - d;
  end
endmodule

module inv_transform_recon #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int COEF_WIDTH = 12,
  localparam int NPIX      = BLOCK_SIZE * BLOCK_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [COEF_WIDTH*NPIX-1:0] coef,
  input  logic [BIT_WIDTH*NPIX-1:0]  ref_pix,
  output logic [BIT_WIDTH*NPIX-1:0]  out,
  output logic                       busy,
  output logic                       done
);
  // T holds the column-pass results. The datapath is wide enough to hold
  // the full-precision constant products without overflow.
  localparam int TW = COEF_WIDTH + 3;
  localparam int PW = TW + 18;
  localparam logic signed [PW-1:0] MAXV = PW'((1 << BIT_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, VPASS, HPASS} state_t;

  state_t                      state, state_n;
  logic [1:0]                  step, step_n;
  logic                        done_n;
  logic [COEF_WIDTH*NPIX-1:0]  coef_q;
  logic [BIT_WIDTH*NPIX-1:0]   ref_q;
  logic [3:0][3:0][TW-1:0]     t;      // t[column][k]
  logic signed [PW-1:0]        bx [4];
  logic signed [PW-1:0]        by [4];
  logic signed [PW-1:0]        sum [4];
  logic [BIT_WIDTH-1:0]        pix [4];

  assign busy = (state != IDLE);

  // Next-state, step counter and completion pulse
  always_comb begin
    state_n = state;
    step_n  = step;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = VPASS;
        step_n  = 2'd0;
      end
      VPASS: begin
        step_n = step + 2'd1;
        if (step == 2'd3) state_n = HPASS;
      end
      HPASS: begin
        step_n = step + 2'd1;
        if (step == 2'd3) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        step_n  = 2'd0;
      end
    endcase
  end

  // Butterfly operands: column `step` of C, or row `step` of T with the rounding offset folded into x0
  always_comb begin
    bx[0] = PW'($signed(coef_q[COEF_WIDTH*(0  + int'(step)) +: COEF_WIDTH]));
    bx[1] = PW'($signed(coef_q[COEF_WIDTH*(4  + int'(step)) +: COEF_WIDTH]));
    bx[2] = PW'($signed(coef_q[COEF_WIDTH*(8  + int'(step)) +: COEF_WIDTH]));
    bx[3] = PW'($signed(coef_q[COEF_WIDTH*(12 + int'(step)) +: COEF_WIDTH]));
    if (state == HPASS) begin
      bx[0] = PW'($signed(t[0][step])) + PW'(4);
      bx[1] = PW'($signed(t[1][step]));
      bx[2] = PW'($signed(t[2][step]));
      bx[3] = PW'($signed(t[3][step]));
    end
  end

  inv_transform_recon_bfly #(.W(PW)) u_bfly (
    .x0(bx[0]), .x1(bx[1]), .x2(bx[2]), .x3(bx[3]),
    .y0(by[0]), .y1(by[1]), .y2(by[2]), .y3(by[3])
  );

  // Descale the row outputs, add the prediction and clamp to the pixel range
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      sum[j] = PW'($signed({1'b0, ref_q[BIT_WIDTH*(4*int'(step) + j) +: BIT_WIDTH]}))
             + (by[j] >>> 3);
      if (sum[j] < 0)         pix[j] = '0;
      else if (sum[j] > MAXV) pix[j] = '1;
      else                    pix[j] = sum[j][BIT_WIDTH-1:0];
    end
  end

  // State, capture registers, T storage and output rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= 2'd0;
      done   <= 1'b0;
      coef_q <= '0;
      ref_q  <= '0;
      t      <= '0;
      out    <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      done  <= done_n;
      if (state == IDLE && start) begin
        coef_q <= coef;
        ref_q  <= ref_pix;
      end
      if (state == VPASS)
        for (int k = 0; k < 4; k++) t[step][k] <= by[k][TW-1:0];
      if (state == HPASS)
        for (int j = 0; j < 4; j++) out[BIT_WIDTH*(4*int'(step) + j) +: BIT_WIDTH] <= pix[j];
    end
  end
endmodule
